// File: rtl/sn_pkg.sv
// Shared types and helpers for the stochastic-number datapath.
// Used by the window decoder and the bipolar encoders.
package sn_pkg;

  localparam int WIN_LOG2_MIN = 1;
  localparam int WIN_LOG2_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sn_state_e;

  function automatic int sn_bipolar(
    input int k,
    input int win_log2
  );
    return 2 * k - (1 << win_log2);
  endfunction

endpackage

// File: rtl/sn_ones_counter.sv
// Gated ones accumulator and valid-bit counter for one window.
// Both clear on window start and on the completing bit.
module sn_ones_counter
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic                sn_in,
  output logic                done,
  output logic [WIN_LOG2:0]   sum
);

  localparam int CW = WIN_LOG2 + 1;
  localparam int N  = 1 << WIN_LOG2;

  logic [CW-1:0] acc;
  logic [CW-1:0] cnt;

  assign done = en && (cnt == CW'(N - 1));
  assign sum  = acc + CW'(sn_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear || done) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= sum;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sn_window_decoder.sv
// Stochastic-to-binary window decoder: counts ones over N valid
// bits and strobes the unipolar or bipolar estimate.
module sn_window_decoder
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cont,
  input  logic                       bipolar,
  input  logic                       sn_in,
  input  logic                       sn_valid,
  output logic                       busy,
  output logic [WIN_LOG2:0]          ones,
  output logic signed [WIN_LOG2+1:0] value_s,
  output logic                       out_valid
);

  localparam int VW = WIN_LOG2 + 2;

  sn_state_e         state;
  sn_state_e         state_nx;
  logic              bip_q;
  logic              win_start;
  logic              cnt_en;
  logic              done;
  logic [WIN_LOG2:0] sum;

  assign busy   = (state == RUN);
  assign cnt_en = (state == RUN) && sn_valid;

  always_comb begin
    state_nx  = state;
    win_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (cont || start) begin
          state_nx  = RUN;
          win_start = 1'b1;
        end
      end
      RUN: begin
        if (done) begin
          if (cont) win_start = 1'b1;
          else      state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  sn_ones_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst_n),
    .clear (win_start),
    .en    (cnt_en),
    .sn_in (sn_in),
    .done  (done),
    .sum   (sum)
  );

  // bipolar is re-sampled at every window start, back-to-back included
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      bip_q     <= 1'b0;
      ones      <= '0;
      value_s   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= done;
      if (win_start) bip_q <= bipolar;
      if (done) begin
        ones <= sum;
        if (bip_q) value_s <= VW'(sn_bipolar(int'(sum), WIN_LOG2));
        else       value_s <= VW'(sum);
      end
    end
  end

endmodule

// File: tb/tb_sn_window_decoder.sv
// Self-checking bench for sn_window_decoder (N=8) with a
// behavioural window model compared on every cycle.
module tb_sn_window_decoder;

  localparam int WL = 3;
  localparam int N  = 1 << WL;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              bipolar = 1'b0;
  logic              sn_in = 1'b0;
  logic              sn_valid = 1'b0;
  logic              busy;
  logic [WL:0]       ones;
  logic signed [WL+1:0] value_s;
  logic              out_valid;

  sn_window_decoder #(.WIN_LOG2(WL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont      (cont),
    .bipolar   (bipolar),
    .sn_in     (sn_in),
    .sn_valid  (sn_valid),
    .busy      (busy),
    .ones      (ones),
    .value_s   (value_s),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;
  bit chk_en = 0;
  int cyc = 0;

  // model state
  bit running = 0;
  bit m_bip = 0;
  bit win[$];
  int m_ones = 0;
  int m_val = 0;
  int m_ov = 0;

  // observed strobes
  int nstrobe = 0;
  int last_ones = 0;
  int last_val = 0;
  int strobe_t[$];

  task automatic check(input string nm, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    int k;
    cyc++;
    if (rst_n) begin
      running = 0;
      win.delete();
      m_ones = 0;
      m_val = 0;
      m_ov = 0;
    end else begin
      m_ov = 0;
      if (!running) begin
        if (cont || start) begin
          running = 1;
          win.delete();
          m_bip = bipolar;
        end
      end else if (sn_valid) begin
        win.push_back(sn_in);
        if (win.size() == N) begin
          k = 0;
          foreach (win[i]) k += win[i];
          m_ones = k;
          m_val = m_bip ? 2 * k - N : k;
          m_ov = 1;
          win.delete();
          if (cont) m_bip = bipolar;
          else running = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(running));
      check("ones", int'(ones), m_ones);
      check("value_s", int'(value_s), m_val);
      check("out_valid", int'(out_valid), m_ov);
      if (out_valid) begin
        nstrobe++;
        last_ones = int'(ones);
        last_val = int'(value_s);
        strobe_t.push_back(cyc);
      end
    end
  end

  task automatic step(input logic s, input logic c, input logic b,
                      input logic v, input logic d, input logic r);
    start = s;
    cont = c;
    bipolar = b;
    sn_valid = v;
    sn_in = d;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic b, input logic [7:0] pat);
    step(1, 0, b, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, b, 1, pat[7-i], 0);
    step(0, 0, b, 0, 0, 0);
    step(0, 0, b, 0, 0, 0);
  endtask

  initial begin
    int n0;
    logic a, bb;

    step(0, 0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0, 0, 1);
    check("rst_ones", int'(ones), 0);
    check("rst_busy", int'(busy), 0);
    step(0, 0, 0, 0, 0, 0);

    // single-shot 1,0,1,1,0,0,1,0
    single(0, 8'b1011_0010);
    check("t1_ones", last_ones, 4);
    check("t1_val", last_val, 4);
    check("t1_strobes", nstrobe, 1);
    check("t1_idle", int'(busy), 0);

    // bipolar boundaries
    single(1, 8'hFF);
    check("bip_ff_ones", last_ones, 8);
    check("bip_ff_val", last_val, 8);
    single(1, 8'h00);
    check("bip_00_ones", last_ones, 0);
    check("bip_00_val", last_val, -8);
    single(1, 8'hA5);
    check("bip_half_val", last_val, 0);

    // continuous, XNOR multiplier source
    strobe_t.delete();
    n0 = nstrobe;
    step(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      a = 1'($urandom);
      bb = 1'($urandom);
      step(0, 1, 1, 1, ~(a ^ bb), 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1'($urandom), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("cont_strobes", nstrobe - n0, 6);
    for (int i = 1; i < strobe_t.size(); i++)
      check("cont_period", strobe_t[i] - strobe_t[i-1], 8);
    check("cont_idle", int'(busy), 0);

    // 50% gated valid, all ones
    n0 = nstrobe;
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 200 && nstrobe == n0; i++)
      step(0, 0, 0, 1'($urandom), 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("gated_strobes", nstrobe - n0, 1);
    check("gated_ones", last_ones, 8);

    // reset mid-window
    n0 = nstrobe;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    check("mid_rst_ones", int'(ones), 0);
    check("mid_rst_val", int'(value_s), 0);
    step(0, 0, 0, 1, 1, 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_nostrobe", nstrobe, n0);
    single(0, 8'b1110_0000);
    check("post_rst_ones", last_ones, 3);

    // start during RUN and bipolar toggle ignored
    n0 = nstrobe;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("mode_strobes", nstrobe - n0, 1);
    check("mode_ones", last_ones, 4);
    check("mode_val", last_val, 4);

    // cont dropped mid-window
    n0 = nstrobe;
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 1, 0);
    check("drop_strobes", nstrobe - n0, 1);
    check("drop_val", last_val, 8);
    check("drop_idle", int'(busy), 0);

    // random soak
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 99) == 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/sn_window_decoder.md
# sn_window_decoder

Stochastic-to-binary decoder at the receiving end of the stochastic datapath. Accepts a serial stochastic bitstream (unipolar or bipolar), counts ones over a fixed window of N = 2^WIN_LOG2 valid bits, and emits the binary estimate with a one-cycle valid strobe. Sits downstream of the LFSR/comparator encoders and the XNOR/AND multipliers. Replaces ad-hoc up-counters with an exact, overflow-free, handshaked converter.

## Interface
- WIN_LOG2, 3: log2 of window length N; legal range 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-high reset; the `_n` suffix is the project's port name only.
- start  in  1  single-shot mode: begin one window; ignored unless in IDLE.
- cont  in  1  1 = continuous back-to-back windows; 0 = single-shot.
- bipolar  in  1  selects encoding of `value_s`; sampled at window start.
- sn_in  in  1  stochastic bit.
- sn_valid  in  1  qualifies `sn_in`; invalid cycles are not counted.
- busy  out  1  high while a window is accumulating.
- ones  out  WIN_LOG2+1  count of ones in the last window, 0..N.
- value_s  out  WIN_LOG2+2  signed; unipolar: `ones`; bipolar: 2*ones − N.
- out_valid  out  1  one-cycle strobe; `ones`/`value_s` updated on this cycle.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN:
    - when `cont`=1, or when `start`=1.
    - On entry: clear the accumulator and the bit counter, and latch `bipolar`.
  - RUN → RUN: on completion, if `cont`=1 at the completing edge. Accumulator and bit counter restart at 0 with no dead cycle.
  - RUN → IDLE: on completion with `cont`=0.
- Counting:
  - In RUN, each cycle with `sn_valid`=1 increments the bit counter, and adds `sn_in` to the accumulator.
  - Bit counter is WIN_LOG2+1 bits wide.
  - Accumulator is WIN_LOG2+1 bits wide. An all-ones window yields exactly N, so no overflow or wrap is possible.
- Completion is the edge that accepts the Nth valid bit. At that edge:
  - `ones` <= accumulator + `sn_in`.
  - `value_s` is computed from that same sum, sign-extended. Bipolar uses (sum<<1) − N.
  - `out_valid` <= 1.
- Outputs hold their values between strobes.
- `start` in RUN is ignored. `cont` falling mid-window lets the current window finish, then the FSM returns to IDLE.
- Changes to `bipolar` take effect only at the next window start.
- Reset (any state, mid-window included): FSM to IDLE, counters 0, `ones`=0, `value_s`=0, `out_valid`=0, `busy`=0. A partial window is discarded and no strobe is issued.

## Timing
- IDLE→RUN on the edge where start/cont is seen. The first bit is counted on the following edge, and `busy`=1 from that cycle.
- Latency: `out_valid` is asserted in the cycle after the edge that accepted the Nth valid bit.
- Minimum window duration is N cycles when `sn_valid` is held high.
- Continuous mode with `sn_valid` held high gives one strobe every N cycles, exactly.
- In the completing cycle, `busy` stays 1 if continuing and drops to 0 if returning to IDLE.
- `sn_valid`=0 cycles stretch the window. No timeout applies.

## Structure
- Shared package `sn_pkg`:
  - FSM state enum (IDLE, RUN).
  - WIN_LOG2 legal bounds.
  - Helper function for bipolar conversion (2*k − N). The bipolar encoders reuse it.
- One sub-module, `sn_ones_counter`: gated accumulator plus bit counter with a `done` output. The FSM, mode latch and output registers stay in the top.

## Test plan
All scenarios use WIN_LOG2=3 (N=8).
- Reset then single-shot: `start` pulse, 8 valid bits 1,0,1,1,0,0,1,0. Expect `ones`=4, `value_s`=4, one `out_valid` pulse, then IDLE with `busy`=0.
- Bipolar boundaries:
  - all-ones window gives `ones`=8, `value_s`=+8.
  - all-zeros window gives `ones`=0, `value_s`=−8.
  - 4 ones gives `value_s`=0.
- Continuous mode, `sn_valid` held high, with the XNOR-multiplier output as source: strobes exactly every 8 cycles with no dropped bit at boundaries. A reference counter in the bench matches every window.
- `sn_valid` gated 50% in a random pattern, all bits 1: window completes after 8 valid bits, with `ones`=8. Invalid cycles are not counted.
- `rst_n` asserted after 5 valid bits: no strobe, outputs 0. The next window counts from zero.
- Mode edge cases:
  - `start` during RUN is ignored.
  - `bipolar` toggled mid-window does not affect the current result.
  - `cont` dropped mid-window: the current window completes, then IDLE.
